// File: rtl/div_pkg.sv
// div_pkg: FSM state type and sizing constants shared by the iterative divider.
`default_nettype none

package div_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } div_state_e;

   // Counter must be able to hold the value WIDTH itself.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// div_step: one restoring shift/subtract iteration on a {remainder, quotient} pair.
`default_nettype none

module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] den_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
);

   logic [WIDTH:0]   rem_sh;
   logic [WIDTH+1:0] diff;
   logic             borrow;
   logic             unused_diff_hi;

   assign rem_sh = {rem_i, quo_i[WIDTH-1]};
   assign diff   = {1'b0, rem_sh} - {2'b00, den_i};
   assign borrow = diff[WIDTH+1];

   // With a zero divisor the top bit is shifted out deliberately; the
   // remainder then ends up equal to the dividend.
   assign unused_diff_hi = diff[WIDTH];

   assign rem_o = borrow ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
   assign quo_o = {quo_i[WIDTH-2:0], ~borrow};

endmodule

`default_nettype wire

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider (DIV/DIVU) with flush and one-cycle done pulse.
// Signed support is built only when DIV_SIGNED_EN is defined.
`default_nettype none

module div_unit
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int CW = cnt_width(WIDTH);

   div_state_e       state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] den_q;
   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;
   logic             busy_q;
   logic             done_q;

   logic             accept_d;
   logic [WIDTH-1:0] rem_step_d;
   logic [WIDTH-1:0] quo_step_d;
   logic [WIDTH-1:0] dvd_abs_d;
   logic [WIDTH-1:0] dsr_abs_d;
   logic [WIDTH-1:0] quo_fix_d;
   logic [WIDTH-1:0] rem_fix_d;

   assign accept_d = start & ~flush & ((state_q == S_IDLE) | (state_q == S_DONE));

   div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem_i (rem_q),
      .quo_i (quo_q),
      .den_i (den_q),
      .rem_o (rem_step_d),
      .quo_o (quo_step_d)
   );

`ifdef DIV_SIGNED_EN
   logic negq_q;
   logic negr_q;
   logic dzero_q;
   logic negq_d;
   logic negr_d;

   assign negq_d    = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
   assign negr_d    = signed_op & dividend[WIDTH-1];
   assign dvd_abs_d = negr_d ? -dividend : dividend;
   assign dsr_abs_d = (signed_op & divisor[WIDTH-1]) ? -divisor : divisor;

   // A zero divisor must report all ones regardless of the dividend sign.
   assign quo_fix_d = dzero_q ? '1 : (negq_q ? -quo_q : quo_q);
   assign rem_fix_d = negr_q ? -rem_q : rem_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         dzero_q <= 1'b0;
      end else if (accept_d) begin
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         dzero_q <= (divisor == '0);
      end
   end
`else
   logic unused_signed_op;

   assign unused_signed_op = signed_op;
   assign dvd_abs_d        = dividend;
   assign dsr_abs_d        = divisor;
   assign quo_fix_d        = quo_q;
   assign rem_fix_d        = rem_q;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         den_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE, S_DONE: begin
                  if (start) begin
                     state_q <= S_CALC;
                     busy_q  <= 1'b1;
                     cnt_q   <= '0;
                     rem_q   <= '0;
                     quo_q   <= dvd_abs_d;
                     den_q   <= dsr_abs_d;
                  end else begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end
               end
               // WIDTH iterations, then one extra CALC cycle to see the terminal count.
               S_CALC: begin
                  if (cnt_q == CW'(WIDTH)) begin
                     state_q <= S_FIX;
                  end else begin
                     rem_q <= rem_step_d;
                     quo_q <= quo_step_d;
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
               S_FIX: begin
                  quotient_q  <= quo_fix_d;
                  remainder_q <= rem_fix_d;
                  state_q     <= S_DONE;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
               end
               default: begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;

endmodule

`default_nettype wire
